modexp_ctrl: RTL and testbench

Sequencer for the RSA modular-exponentiation datapath. Scans an `n`-bit exponent (`key`) MSB-first, using left-to-right square-and-multiply. Issues one modular-multiplier operation at a time through a start/done handshake and drives the accumulator load/write strobes and the operand-B mux select. It replaces free-running step counting with an exact, bit-driven schedule and reports completion with a one-cycle `done` pulse.

---
 rtl/modexp_ctrl.sv | 141 ++++++++++++++
 tb/tb_modexp_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer for the modular-exponentiation datapath.
// The exponent is scanned MSB-first. One modular multiplication is issued at a
// time through a start/done handshake with the multiplier. Every output is a
// register loaded from the decode of the next state, so each output matches
// the current state's Moore decode without any combinational path to a port.
module modexp_ctrl #(
    parameter int unsigned n  = 6,
    parameter int unsigned CW = $clog2(2 * n + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [n-1:0]  key,
    input  logic          mul_done,
    output logic          mul_start,
    output logic          mux_sel,
    output logic          acc_load_one,
    output logic          acc_load_msg,
    output logic          acc_we,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] mul_count
);

    localparam int unsigned IW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        SQ_REQ,
        SQ_WAIT,
        SQ_WB,
        MUL_REQ,
        MUL_WAIT,
        MUL_WB,
        NEXT,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [n-1:0]  e_r, e_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [CW-1:0] count_nx;
    logic          mul_start_nx, mux_sel_nx, load_one_nx, load_msg_nx;
    logic          acc_we_nx, busy_nx, done_nx;

    // Position of the highest set bit; 0 when no bit is set.
    function automatic logic [IW-1:0] msb_pos(input logic [n-1:0] v);
        msb_pos = '0;
        for (int i = 0; i < int'(n); i++) begin
            if (v[i]) msb_pos = IW'(i);
        end
    endfunction

    // Next state, scan index, exponent latch, op counter and output decode.
    always_comb begin
        state_nx = state;
        e_nx     = e_r;
        idx_nx   = idx;
        count_nx = mul_count;

        case (state)
            IDLE: begin
                if (start) begin
                    e_nx     = key;
                    count_nx = '0;
                    idx_nx   = msb_pos(key);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (e_r == '0 || idx == '0) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx - IW'(1);
                    state_nx = SQ_REQ;
                end
            end
            SQ_REQ: begin
                count_nx = mul_count + CW'(1);
                state_nx = SQ_WAIT;
            end
            SQ_WAIT:  if (mul_done) state_nx = SQ_WB;
            SQ_WB:    state_nx = e_r[idx] ? MUL_REQ : NEXT;
            MUL_REQ: begin
                count_nx = mul_count + CW'(1);
                state_nx = MUL_WAIT;
            end
            MUL_WAIT: if (mul_done) state_nx = MUL_WB;
            MUL_WB:   state_nx = NEXT;
            NEXT: begin
                if (idx == '0) begin
                    state_nx = DONE;
                end else begin
                    idx_nx   = idx - IW'(1);
                    state_nx = SQ_REQ;
                end
            end
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        mul_start_nx = (state_nx == SQ_REQ) || (state_nx == MUL_REQ);
        mux_sel_nx   = (state_nx == MUL_REQ) || (state_nx == MUL_WAIT) || (state_nx == MUL_WB);
        acc_we_nx    = (state_nx == SQ_WB) || (state_nx == MUL_WB);
        load_one_nx  = (state_nx == LOAD) && (e_nx == '0);
        load_msg_nx  = (state_nx == LOAD) && (e_nx != '0);
        busy_nx      = (state_nx != IDLE);
        done_nx      = (state_nx == DONE);
    end

    // State, datapath-control registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            e_r          <= '0;
            idx          <= '0;
            mul_count    <= '0;
            mul_start    <= 1'b0;
            mux_sel      <= 1'b0;
            acc_load_one <= 1'b0;
            acc_load_msg <= 1'b0;
            acc_we       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            e_r          <= e_nx;
            idx          <= idx_nx;
            mul_count    <= count_nx;
            mul_start    <= mul_start_nx;
            mux_sel      <= mux_sel_nx;
            acc_load_one <= load_one_nx;
            acc_load_msg <= load_msg_nx;
            acc_we       <= acc_we_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: a fixed vector table, a randomized
// square-and-multiply reference, a mid-run reset sequence and back-to-back runs.
module tb_modexp_ctrl;

    localparam int unsigned N  = 6;
    localparam int unsigned CW = $clog2(2 * N + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [N-1:0]  key;
    logic          mul_done;
    logic          mul_start, mux_sel, acc_load_one, acc_load_msg, acc_we, busy, done;
    logic [CW-1:0] mul_count;

    modexp_ctrl #(.n(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .key          (key),
        .mul_done     (mul_done),
        .mul_start    (mul_start),
        .mux_sel      (mux_sel),
        .acc_load_one (acc_load_one),
        .acc_load_msg (acc_load_msg),
        .acc_we       (acc_we),
        .busy         (busy),
        .done         (done),
        .mul_count    (mul_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Per-operation multiplier latency (WAIT cycles) used by the run task.
    int ks[16];

    // Observations of the most recent run.
    logic [15:0] r_seq;
    int r_nops, r_lat, r_cnt, r_nwe, r_nlo, r_nlm, r_proto;
    bit r_seen;

    typedef struct {
        logic [N-1:0] key;
        int           k;
        bit           noisy;
        logic [15:0]  seq;
        int           nops;
        int           lat;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: left-to-right square-and-multiply schedule (0 = square, 1 = multiply).
    function automatic void model(input logic [N-1:0] kk, output logic [15:0] seq,
                                  output int nops, output int msb);
        msb  = 0;
        seq  = '0;
        nops = 0;
        for (int i = 0; i < int'(N); i++) if (kk[i]) msb = i;
        if (kk != '0) begin
            for (int i = msb - 1; i >= 0; i--) begin
                seq[nops] = 1'b0;
                nops++;
                if (kk[i]) begin
                    seq[nops] = 1'b1;
                    nops++;
                end
            end
        end
    endfunction

    // One operation: start in the first negedge window, then act as the multiplier.
    task automatic run(input logic [N-1:0] kk, input bit noisy);
        int  cyc, rem;
        bit  outstanding, cur_mux;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        start    = 1'b1;
        key      = kk;
        mul_done = 1'b0;
        cyc = 0; rem = 0; outstanding = 0; cur_mux = 0;
        r_seq = '0; r_nops = 0; r_lat = -1; r_cnt = -1;
        r_nwe = 0; r_nlo = 0; r_nlm = 0; r_proto = 0; r_seen = 0;
        while (!r_seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            mul_done = 1'b0;
            if (noisy && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                key   = N'($urandom);
            end
            if (!busy) r_proto++;
            if (mul_start) begin
                if (outstanding) r_proto++;
                outstanding = 1;
                cur_mux     = mux_sel;
                if (r_nops < 16) begin
                    r_seq[r_nops] = mux_sel;
                    rem           = ks[r_nops];
                end else begin
                    rem = 1;
                end
                r_nops++;
                if (noisy) mul_done = 1'($urandom_range(0, 1));
            end else if (rem > 0) begin
                if (mux_sel != cur_mux) r_proto++;
                rem--;
                if (rem == 0) mul_done = 1'b1;
            end else begin
                if (noisy) mul_done = 1'($urandom_range(0, 1));
            end
            if (acc_we) begin
                if (!outstanding) r_proto++;
                if (mux_sel != cur_mux) r_proto++;
                outstanding = 0;
                r_nwe++;
            end
            r_nlo += int'(acc_load_one);
            r_nlm += int'(acc_load_msg);
            if (done) begin
                r_seen = 1;
                r_lat  = cyc;
                r_cnt  = int'(mul_count);
                start  = 1'b0;
                if (outstanding) r_proto++;
            end
        end
        check("done_seen", int'(r_seen), 1);
    endtask

    task automatic check_run(input logic [N-1:0] kk, input logic [15:0] seq,
                             input int nops, input int lat);
        logic [15:0] mask;
        mask = (16'(1) << nops) - 16'(1);
        check("latency", r_lat, lat);
        check("mul_count", r_cnt, nops);
        check("op_count", r_nops, nops);
        check("op_sequence", int'(r_seq & mask), int'(seq));
        check("acc_we_count", r_nwe, nops);
        check("load_one", r_nlo, (kk == '0) ? 1 : 0);
        check("load_msg", r_nlm, (kk == '0) ? 0 : 1);
        check("protocol", r_proto, 0);
    endtask

    task automatic check_quiet(input string name);
        check(name, int'({mul_start, mux_sel, acc_load_one, acc_load_msg,
                          acc_we, busy, done, mul_count}), 0);
    endtask

    initial begin
        logic [15:0] mseq;
        int          mnops, mmsb, mlat;
        logic [N-1:0] rk;
        bit          prev, found;

        reset_n  = 1'b0;
        start    = 1'b0;
        key      = '0;
        mul_done = 1'b0;

        tbl[0] = '{key: 6'd0,  k: 1, noisy: 0, seq: 16'h0000, nops: 0,  lat: 2};
        tbl[1] = '{key: 6'd1,  k: 1, noisy: 0, seq: 16'h0000, nops: 0,  lat: 2};
        tbl[2] = '{key: 6'd45, k: 1, noisy: 0, seq: 16'h0094, nops: 8,  lat: 31};
        tbl[3] = '{key: 6'd63, k: 2, noisy: 1, seq: 16'h02AA, nops: 10, lat: 47};
        tbl[4] = '{key: 6'd32, k: 1, noisy: 0, seq: 16'h0000, nops: 5,  lat: 22};
        tbl[5] = '{key: 6'd2,  k: 1, noisy: 0, seq: 16'h0000, nops: 1,  lat: 6};
        tbl[6] = '{key: 6'd3,  k: 1, noisy: 0, seq: 16'h0002, nops: 2,  lat: 9};

        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        reset_n = 1'b1;

        // Vector table; consecutive runs are back-to-back (start in first IDLE cycle).
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 16; i++) ks[i] = tbl[v].k;
            run(tbl[v].key, tbl[v].noisy);
            check_run(tbl[v].key, tbl[v].seq, tbl[v].nops, tbl[v].lat);
        end

        // Randomized keys and multiplier latencies against the reference schedule.
        for (int t = 0; t < 12; t++) begin
            rk = (t == 0) ? N'(63) : N'($urandom_range(0, 63));
            for (int i = 0; i < 16; i++) ks[i] = $urandom_range(1, 5);
            model(rk, mseq, mnops, mmsb);
            mlat = 2 + mmsb;
            for (int i = 0; i < mnops; i++) mlat += 2 + ks[i];
            run(rk, 1'b1);
            check_run(rk, mseq, mnops, mlat);
        end

        // Reset asserted during MUL_WAIT of a key=45 run.
        @(negedge clk);
        start = 1'b1;
        key   = N'(45);
        prev  = 0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start    = 1'b0;
            mul_done = prev;
            if (prev && mux_sel) found = 1;
            prev = mul_start;
        end
        check("reach_mul_wait", int'(found), 1);
        mul_done = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_quiet("reset_immediate");
        repeat (2) begin
            @(negedge clk);
            check_quiet("reset_held");
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("post_reset_idle");
        end
        for (int i = 0; i < 16; i++) ks[i] = 1;
        run(N'(2), 1'b0);
        check_run(N'(2), 16'h0000, 1, 6);

        // Back-to-back: key=3 started in the first IDLE cycle after done.
        run(N'(3), 1'b0);
        check_run(N'(3), 16'h0002, 2, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
